dp_rr_sched: RTL and testbench

Round-robin scheduler that shares one 12-bit registered arithmetic datapath (operands a/b/c, enable, result f) among NREQ requesters. It accepts one operand set at a time through a valid/ready handshake and drives the datapath operands plus a one-cycle enable. It then waits the fixed datapath latency and returns the captured result, tagged with the requester ID, on a valid/ready response channel. It sits between the requester ports and the single datapath instance.

---
 rtl/dp_rr_sched.sv | 136 +++++++++++++
 tb/tb_dp_rr_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_rr_sched.sv
// dp_rr_sched: round-robin front end for one shared
// registered arithmetic datapath, one op in flight.
module dp_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 12,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  output logic              dp_en,
  output logic [W-1:0]      dp_a,
  output logic [W-1:0]      dp_b,
  output logic [W-1:0]      dp_c,
  input  logic [W-1:0]      dp_f,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [IDW-1:0]  r_last;
  logic            r_dp_en;
  logic [W-1:0]    r_dp_a;
  logic [W-1:0]    r_dp_b;
  logic [W-1:0]    r_dp_c;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [W-1:0]    r_rsp_data;
  logic            r_busy;

  logic            w_found;
  logic [IDW-1:0]  w_gnt;
  logic [NREQ-1:0] w_ready;

  // Pick first valid requester after the last grant.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found &&
          req_valid[IDW'((int'(r_last) + k) % NREQ)]) begin
        w_found = 1'b1;
        w_gnt   = IDW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  // One-hot accept, only while idle.
  always_comb begin
    w_ready = '0;
    if (r_state == IDLE && w_found)
      w_ready[w_gnt] = 1'b1;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= IDW'(NREQ - 1);
      r_dp_en     <= 1'b0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_dp_c      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_dp_a   <= req_a[w_gnt*W +: W];
            r_dp_b   <= req_b[w_gnt*W +: W];
            r_dp_c   <= req_c[w_gnt*W +: W];
            r_rsp_id <= w_gnt;
            r_last   <= w_gnt;
            r_dp_en  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_dp_en <= 1'b0;
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(LAT - 1)) begin
            r_rsp_data  <= dp_f;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign dp_en     = r_dp_en;
  assign dp_a      = r_dp_a;
  assign dp_b      = r_dp_b;
  assign dp_c      = r_dp_c;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dp_rr_sched.sv
// tb_dp_rr_sched: directed bench for dp_rr_sched
// with a two-stage (a|c)+1 datapath model.
module tb_dp_rr_sched;
  localparam int NREQ = 4;
  localparam int W    = 12;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*W-1:0] req_c;
  logic              dp_en;
  logic [W-1:0]      dp_a, dp_b, dp_c;
  logic [W-1:0]      dp_f = '0;
  logic [W-1:0]      s1 = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] ta [4] = '{12'h001, 12'h010, 12'h00F, 12'h400};
  logic [W-1:0] tb_[4] = '{12'h111, 12'h222, 12'h123, 12'h444};
  logic [W-1:0] tc [4] = '{12'h0A0, 12'h202, 12'h0F0, 12'h00C};
  // hand-computed (a|c)+1 per requester
  logic [W-1:0] ef [4] = '{12'h0A2, 12'h213, 12'h100, 12'h40D};

  dp_rr_sched #(.NREQ(NREQ), .W(W), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .dp_en(dp_en), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .dp_f(dp_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dp_en) s1 <= (dp_a | dp_c) + 12'd1;
    dp_f <= s1;
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tb_[i];
      req_c[i*W +: W] = tc[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g,
                            output bit ok);
    ok = 0;
    g  = '0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req_ready != 0) begin
        g  = req_ready;
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    step();
    step();
    n_chk++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    n_chk++; if (dp_en !== 1'b0) begin n_fail++; $display("FAIL rst_dp_en got %b exp 0", dp_en); end
    n_chk++; if (dp_a !== 12'h0) begin n_fail++; $display("FAIL rst_dp_a got %h exp 0", dp_a); end
    n_chk++; if (dp_b !== 12'h0) begin n_fail++; $display("FAIL rst_dp_b got %h exp 0", dp_b); end
    n_chk++; if (dp_c !== 12'h0) begin n_fail++; $display("FAIL rst_dp_c got %h exp 0", dp_c); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    n_chk++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rst_rsp_id got %0d exp 0", rsp_id); end
    n_chk++; if (rsp_data !== 12'h0) begin n_fail++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    int ng = 0;
    int nr = 0;
    int tlast = 0;
    bit drop = 0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int cyc = 0; cyc < 100 && nr < 6; cyc++) begin
      if (drop) begin
        req_valid = '0;
        drop = 0;
      end
      #1;
      if (rsp_valid) begin
        n_chk++; if (rsp_id !== IDW'(seq[nr])) begin n_fail++; $display("FAIL rr_rsp_id[%0d] got %0d exp %0d", nr, rsp_id, seq[nr]); end
        n_chk++; if (rsp_data !== ef[seq[nr]]) begin n_fail++; $display("FAIL rr_rsp_data[%0d] got %h exp %h", nr, rsp_data, ef[seq[nr]]); end
        nr++;
      end
      if (req_ready != 0 && ng < 6) begin
        n_chk++; if (req_ready !== (4'(1) << seq[ng])) begin n_fail++; $display("FAIL rr_grant[%0d] got %b exp idx %0d", ng, req_ready, seq[ng]); end
        if (ng > 0) begin
          n_chk++; if (cyc - tlast != 5) begin n_fail++; $display("FAIL rr_spacing[%0d] got %0d exp 5", ng, cyc - tlast); end
        end
        tlast = cyc;
        ng++;
        if (ng == 6) drop = 1;
      end
      step();
    end
    n_chk++; if (nr != 6) begin n_fail++; $display("FAIL rr_timeout got %0d responses exp 6", nr); end
    req_valid = '0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    step();
    req_valid = '0;
    #1;
    n_chk++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL single_ready_t1 got %b exp 0", req_ready); end
    n_chk++; if (dp_en !== 1'b1) begin n_fail++; $display("FAIL single_dp_en_t1 got %b exp 1", dp_en); end
    n_chk++; if (dp_a !== 12'h00F) begin n_fail++; $display("FAIL single_dp_a got %h exp 00f", dp_a); end
    n_chk++; if (dp_b !== 12'h123) begin n_fail++; $display("FAIL single_dp_b got %h exp 123", dp_b); end
    n_chk++; if (dp_c !== 12'h0F0) begin n_fail++; $display("FAIL single_dp_c got %h exp 0f0", dp_c); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
    step();
    n_chk++; if (dp_en !== 1'b0) begin n_fail++; $display("FAIL single_dp_en_t2 got %b exp 0", dp_en); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_t2 got %b exp 0", rsp_valid); end
    step();
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_t3 got %b exp 0", rsp_valid); end
    step();
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_t4 got %b exp 1", rsp_valid); end
    n_chk++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_rsp_id got %0d exp 2", rsp_id); end
    n_chk++; if (rsp_data !== 12'h100) begin n_fail++; $display("FAIL single_rsp_data got %h exp 100", rsp_data); end
    step();
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_t5 got %b exp 0", rsp_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_t5 got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] g;
    bit ok;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    wait_grant(g, ok);
    n_chk++; if (!ok || g !== 4'b0001) begin n_fail++; $display("FAIL bp_grant got %b exp 0001", g); end
    step();
    req_valid = 4'b0100;
    wait_rsp(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_rsp_timeout got none exp rsp_valid"); end
    for (int i = 0; i < 6; i++) begin
      #1;
      n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, rsp_valid); end
      n_chk++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_id[%0d] got %0d exp 0", i, rsp_id); end
      n_chk++; if (rsp_data !== 12'h0A2) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp 0a2", i, rsp_data); end
      n_chk++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", i, req_ready); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d] got %b exp 1", i, busy); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    #1;
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b exp 0", rsp_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy got %b exp 0", busy); end
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next_grant got %b exp 0100", req_ready); end
    step();
    req_valid = '0;
    wait_rsp(ok);
    n_chk++; if (!ok || rsp_id !== 2'd2) begin n_fail++; $display("FAIL bp_next_id got %0d exp 2", rsp_id); end
    n_chk++; if (rsp_data !== 12'h100) begin n_fail++; $display("FAIL bp_next_data got %h exp 100", rsp_data); end
    step();
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] g;
    bit ok;
    req_valid = 4'b1000;
    wait_grant(g, ok);
    n_chk++; if (!ok || g !== 4'b1000) begin n_fail++; $display("FAIL fair_pre_grant got %b exp 1000", g); end
    step();
    req_valid = '0;
    wait_rsp(ok);
    step();
    req_valid = 4'b1010;
    wait_grant(g, ok);
    n_chk++; if (!ok || g !== 4'b0010) begin n_fail++; $display("FAIL fair_first got %b exp 0010", g); end
    step();
    wait_grant(g, ok);
    n_chk++; if (!ok || g !== 4'b1000) begin n_fail++; $display("FAIL fair_second got %b exp 1000", g); end
    step();
    req_valid = '0;
    wait_rsp(ok);
    n_chk++; if (!ok || rsp_id !== 2'd3) begin n_fail++; $display("FAIL fair_rsp_id got %0d exp 3", rsp_id); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g;
    bit ok;
    req_valid = 4'b0010;
    wait_grant(g, ok);
    n_chk++; if (!ok || g !== 4'b0010) begin n_fail++; $display("FAIL rmid_grant got %b exp 0010", g); end
    step();
    req_valid = '0;
    step();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_wait got %b exp 1", busy); end
    rst = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", busy); end
    n_chk++; if (dp_a !== 12'h0) begin n_fail++; $display("FAIL rmid_dp_a got %h exp 0", dp_a); end
    n_chk++; if (dp_b !== 12'h0) begin n_fail++; $display("FAIL rmid_dp_b got %h exp 0", dp_b); end
    n_chk++; if (dp_c !== 12'h0) begin n_fail++; $display("FAIL rmid_dp_c got %h exp 0", dp_c); end
    n_chk++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rmid_rsp_id got %0d exp 0", rsp_id); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_valid got %b exp 0", rsp_valid); end
    n_chk++; if (dp_en !== 1'b0) begin n_fail++; $display("FAIL rmid_dp_en got %b exp 0", dp_en); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_hold_valid[%0d] got %b exp 0", i, rsp_valid); end
    end
    rst = 1'b0;
    step();
    req_valid = 4'b0101;
    #1;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_first got %b exp 0001", req_ready); end
    step();
    req_valid = '0;
    wait_rsp(ok);
    n_chk++; if (!ok || rsp_id !== 2'd0) begin n_fail++; $display("FAIL rmid_rsp_id_after got %0d exp 0", rsp_id); end
    n_chk++; if (rsp_data !== 12'h0A2) begin n_fail++; $display("FAIL rmid_rsp_data got %h exp 0a2", rsp_data); end
    step();
  endtask

  task automatic test_drop();
    logic [NREQ-1:0] g;
    bit ok;
    bit seen = 0;
    bit got = 0;
    req_valid = 4'b0001;
    wait_grant(g, ok);
    n_chk++; if (!ok || g !== 4'b0001) begin n_fail++; $display("FAIL drop_grant got %b exp 0001", g); end
    step();
    req_valid = '0;
    step();
    req_valid = 4'b0010;
    #1;
    n_chk++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL drop_ready_wait got %b exp 0", req_ready); end
    step();
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (req_ready[1]) seen = 1;
      if (rsp_valid) begin
        got = 1;
        n_chk++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL drop_rsp_id got %0d exp 0", rsp_id); end
      end
      step();
    end
    n_chk++; if (!got) begin n_fail++; $display("FAIL drop_rsp_timeout got none exp rsp_valid"); end
    n_chk++; if (seen) begin n_fail++; $display("FAIL drop_never_granted got 1 exp 0"); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
